// File: rtl/blockram_arb_pkg.sv
// blockram_arb_pkg: pipeconnect request/response records and the default block window.
package blockram_arb_pkg;
  localparam logic [15:0] BLOCKRAM_BASE = 16'h4000;
  typedef struct packed {
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [31:0] wd;
    logic [3:0]  wbe;
  } req_t;
  typedef struct packed {
    logic        hold;
    logic [31:0] rd;
  } res_t;
endpackage

// File: rtl/blockram_arb_dpram.sv
// blockram_arb_dpram: dual-port RAM with byte enables and old-data read-during-write.
module blockram_arb_dpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    wren_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  input  logic                    wren_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   data_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  output logic [DATA_WIDTH-1:0]   q_b
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (wren_a && be_a[i]) mem[addr_a][8*i +: 8] <= data_a[8*i +: 8];
      if (wren_b && be_b[i]) mem[addr_b][8*i +: 8] <= data_b[8*i +: 8];
    end
  end
endmodule

// File: rtl/blockram_arb.sv
// blockram_arb: two-master round-robin controller for a word-addressed on-chip RAM window.
module blockram_arb
  import blockram_arb_pkg::*;
#(
  parameter int          SIZE    = 10,
  parameter logic [15:0] BASE    = BLOCKRAM_BASE,
  parameter bit          OUT_REG = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  req_t req0,
  output res_t res0,
  input  req_t req1,
  output res_t res1
);
  logic sel0, sel1, gnt1, any_gnt, last_q, last_d, v1_q, v1_d, own1_q, v2_q, own2_q, v_o, own_o;
  logic [31:0] q, q_r, rd, q_b_unused;
  logic unused_bits;
  req_t rg;
  always_comb begin
    sel0 = req0.a[31:16] == BASE && (req0.r || req0.w);
    sel1 = req1.a[31:16] == BASE && (req1.r || req1.w);
    gnt1 = sel1 && (!sel0 || !last_q);
    any_gnt = sel0 || sel1;
    rg = gnt1 ? req1 : req0;
    last_d = any_gnt ? gnt1 : last_q;
    v1_d = any_gnt && rg.r;
    v_o = OUT_REG ? v2_q : v1_q;
    own_o = OUT_REG ? own2_q : own1_q;
    rd = OUT_REG ? q_r : q;
    res0.hold = rst && sel0 && gnt1;
    res1.hold = rst && sel1 && !gnt1;
    res0.rd = (v_o && !own_o) ? rd : '0;
    res1.rd = (v_o && own_o) ? rd : '0;
  end
  // Reset discards in-flight reads but leaves RAM contents alone.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
      v1_q   <= 1'b0;
      own1_q <= 1'b0;
      v2_q   <= 1'b0;
      own2_q <= 1'b0;
      q_r    <= '0;
    end else begin
      last_q <= last_d;
      v1_q   <= v1_d;
      own1_q <= gnt1;
      v2_q   <= v1_q;
      own2_q <= own1_q;
      q_r    <= q;
    end
  end
  assign unused_bits = ^{rg.a[31:SIZE+2], rg.a[1:0], q_b_unused};
  blockram_arb_dpram #(.DATA_WIDTH(32), .ADDR_WIDTH(SIZE)) u_ram (
    .clk(clock),
    .wren_a(rst && any_gnt && rg.w),
    .addr_a(rg.a[SIZE+1:2]),
    .data_a(rg.wd),
    .be_a(rg.wbe),
    .q_a(q),
    .wren_b(1'b0),
    .addr_b('0),
    .data_b('0),
    .be_b('0),
    .q_b(q_b_unused)
  );
endmodule

// File: tb/tb_blockram_arb.sv
// tb_blockram_arb: directed table, reset corner cases and random traffic against a RAM/arbiter model.
module tb_blockram_arb;
  import blockram_arb_pkg::*;
  logic clock, rst;
  req_t req0, req1;
  res_t r0a, r1a, r0b, r1b;
  blockram_arb #(.SIZE(10), .BASE(16'h4000), .OUT_REG(1'b0)) dut_a (
    .clock(clock), .rst(rst), .req0(req0), .res0(r0a), .req1(req1), .res1(r1a));
  blockram_arb #(.SIZE(10), .BASE(16'h4000), .OUT_REG(1'b1)) dut_b (
    .clock(clock), .rst(rst), .req0(req0), .res0(r0b), .req1(req1), .res1(r1b));
  always #5 clock = ~clock;

  typedef struct {
    req_t        q0;
    req_t        q1;
    logic        h0;
    logic        h1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  int n_chk, n_pass;
  logic [31:0] mem [0:1023];
  logic last, eh0, eh1;
  logic [31:0] p1 [2];
  logic [31:0] p2 [2];
  vec_t tbl [15];
  req_t idle, ra, rb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic req_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
    req_t q;
    q.r = r; q.w = w; q.a = a; q.wd = wd; q.wbe = be;
    return q;
  endfunction
  function automatic req_t rdq(input logic [31:0] a); return mk(1'b1, 1'b0, a, 32'h0, 4'h0); endfunction
  function automatic req_t wrq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    return mk(1'b0, 1'b1, a, d, be);
  endfunction

  function automatic req_t rnd();
    req_t q;
    q.a = (($urandom_range(0, 7) == 0) ? 32'h5000_0000 : 32'h4000_0000)
        | (($urandom_range(0, 3) == 0) ? 32'h0000_1000 : 32'h0)
        | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    q.r = 1'($urandom); q.w = 1'($urandom); q.wd = $urandom; q.wbe = 4'($urandom);
    return q;
  endfunction

  function automatic logic hit(input req_t q);
    return q.a[31:16] == 16'h4000 && (q.r || q.w);
  endfunction

  // One accepted access per cycle: pick the winner, read old data, then merge the write.
  task automatic model(input req_t a, input req_t b);
    logic s0, s1;
    int win;
    req_t g;
    logic [9:0] idx;
    logic [31:0] nrd [2];
    s0 = hit(a); s1 = hit(b);
    nrd[0] = 32'h0; nrd[1] = 32'h0;
    win = (s0 && s1) ? (last ? 0 : 1) : (s1 ? 1 : 0);
    eh0 = s0 && win != 0;
    eh1 = s1 && win != 1;
    if (s0 || s1) begin
      last = (win == 1);
      g = (win == 1) ? b : a;
      idx = g.a[11:2];
      if (g.r) nrd[win] = mem[idx];
      if (g.w) for (int i = 0; i < 4; i++) if (g.wbe[i]) mem[idx][8*i +: 8] = g.wd[8*i +: 8];
    end
    p2 = p1;
    p1 = nrd;
  endtask

  task automatic apply_check(input req_t a, input req_t b);
    req0 = a; req1 = b;
    #1;
    check("rd0_lat1", r0a.rd, p1[0]);
    check("rd1_lat1", r1a.rd, p1[1]);
    check("rd0_lat2", r0b.rd, p2[0]);
    check("rd1_lat2", r1b.rd, p2[1]);
    model(a, b);
    check("hold0", {31'd0, r0a.hold}, {31'd0, eh0});
    check("hold1", {31'd0, r1a.hold}, {31'd0, eh1});
    check("hold0_oreg", {31'd0, r0b.hold}, {31'd0, eh0});
    check("hold1_oreg", {31'd0, r1b.hold}, {31'd0, eh1});
  endtask

  task automatic step(input req_t a, input req_t b);
    apply_check(a, b);
    @(negedge clock);
  endtask

  task automatic in_reset(input int n, input req_t a, input req_t b);
    rst = 1'b0;
    p1 = '{32'h0, 32'h0}; p2 = '{32'h0, 32'h0}; last = 1'b1; eh0 = 1'b0; eh1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      req0 = a; req1 = b;
      #1;
      check("rst_rd0", r0a.rd, 32'h0);
      check("rst_rd1", r1a.rd, 32'h0);
      check("rst_rd0_oreg", r0b.rd, 32'h0);
      check("rst_rd1_oreg", r1b.rd, 32'h0);
      check("rst_hold0", {31'd0, r0a.hold | r0b.hold}, 32'h0);
      check("rst_hold1", {31'd0, r1a.hold | r1b.hold}, 32'h0);
      @(negedge clock);
    end
    rst = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    clock = 1'b0; rst = 1'b1; idle = '0; req0 = '0; req1 = '0;
    #2;
    in_reset(2, rdq(32'h4000_0000), rdq(32'h4000_0000));

    tbl[0]  = '{wrq(32'h4000_0010, 32'hDEADBEEF, 4'hF), idle, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{rdq(32'h4000_0010), idle, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{wrq(32'h4000_0000, 32'h11223344, 4'hF), idle, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{wrq(32'h4000_0004, 32'h55667788, 4'hF), idle, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{rdq(32'h4000_0000), rdq(32'h4000_0000), 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{rdq(32'h4000_0000), rdq(32'h4000_0000), 1'b0, 1'b1, 32'h0, 32'h11223344};
    tbl[6]  = '{rdq(32'h4000_0004), rdq(32'h4000_0000), 1'b1, 1'b0, 32'h11223344, 32'h0};
    tbl[7]  = '{rdq(32'h4000_0004), rdq(32'h4000_0004), 1'b0, 1'b1, 32'h0, 32'h11223344};
    tbl[8]  = '{idle, rdq(32'h4000_0004), 1'b0, 1'b0, 32'h55667788, 32'h0};
    tbl[9]  = '{wrq(32'h4000_0000, 32'h0000AAAA, 4'b0011), idle, 1'b0, 1'b0, 32'h0, 32'h55667788};
    tbl[10] = '{rdq(32'h4000_1000), rdq(32'h5000_0000), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[11] = '{idle, idle, 1'b0, 1'b0, 32'h1122AAAA, 32'h0};
    tbl[12] = '{idle, mk(1'b1, 1'b1, 32'h4000_0004, 32'hCAFEF00D, 4'hF), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[13] = '{idle, rdq(32'h4000_0004), 1'b0, 1'b0, 32'h0, 32'h55667788};
    tbl[14] = '{idle, idle, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D};
    for (int i = 0; i < 15; i++) begin
      apply_check(tbl[i].q0, tbl[i].q1);
      check($sformatf("tbl%0d_hold0", i), {31'd0, r0a.hold}, {31'd0, tbl[i].h0});
      check($sformatf("tbl%0d_hold1", i), {31'd0, r1a.hold}, {31'd0, tbl[i].h1});
      check($sformatf("tbl%0d_rd0", i), r0a.rd, tbl[i].rd0);
      check($sformatf("tbl%0d_rd1", i), r1a.rd, tbl[i].rd1);
      @(negedge clock);
    end

    // Reset lands while a read is in flight; a write during reset must not land.
    step(rdq(32'h4000_0000), idle);
    in_reset(2, wrq(32'h4000_0004, 32'hFFFFFFFF, 4'hF), rdq(32'h4000_0000));
    apply_check(rdq(32'h4000_0000), rdq(32'h4000_0000));
    check("post_rst_hold0", {31'd0, r0a.hold}, 32'h0);
    check("post_rst_hold1", {31'd0, r1a.hold}, 32'h1);
    @(negedge clock);
    apply_check(rdq(32'h4000_0004), rdq(32'h4000_0000));
    check("post_rst_rd0", r0a.rd, 32'h1122AAAA);
    @(negedge clock);
    apply_check(rdq(32'h4000_0004), idle);
    check("post_rst_rd1", r1a.rd, 32'h1122AAAA);
    check("post_rst_rd0_oreg", r0b.rd, 32'h1122AAAA);
    @(negedge clock);
    apply_check(idle, idle);
    check("kept_rd0", r0a.rd, 32'hCAFEF00D);
    check("post_rst_rd1_oreg", r1b.rd, 32'h1122AAAA);
    @(negedge clock);
    apply_check(idle, idle);
    check("kept_rd0_oreg", r0b.rd, 32'hCAFEF00D);
    @(negedge clock);

    for (int w = 0; w < 16; w++) step(wrq(32'h4000_0000 | 32'(w << 2), $urandom, 4'hF), idle);
    for (int w = 0; w < 3; w++) step(rdq(32'h4000_0000 | 32'(w << 2)), idle);
    step(wrq(32'h5000_0000, 32'h0BADF00D, 4'hF), idle);
    step(rdq(32'h4000_0000), idle);

    ra = idle; rb = idle;
    for (int i = 0; i < 400; i++) begin
      if (!eh0) ra = rnd();
      if (!eh1) rb = rnd();
      step(ra, rb);
    end
    step(idle, idle);
    step(idle, idle);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
